// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in cycles,
// with a per-period valid strobe and a timeout flag when the input stops toggling.
module period_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 timeout
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   synced_s;
  logic                   rise_s;
  logic                   fall_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_nxt_s;
  logic [CNT_WIDTH-1:0]   hreg_r;
  logic [CNT_WIDTH-1:0]   hreg_nxt_s;
  logic [CNT_WIDTH-1:0]   period_nxt_s;
  logic [CNT_WIDTH-1:0]   high_nxt_s;
  logic                   valid_nxt_s;
  logic                   timeout_nxt_s;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign synced_s = sync_r[SYNC_STAGES-1];
  assign rise_s   = synced_s & ~prev_r;
  assign fall_s   = ~synced_s & prev_r;

  // Next-state logic; a rise beats saturation so a max-length period is still reported.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    hreg_nxt_s    = hreg_r;
    period_nxt_s  = period;
    high_nxt_s    = high_time;
    valid_nxt_s   = 1'b0;
    timeout_nxt_s = timeout;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = MEASURE;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          period_nxt_s  = cnt_r;
          high_nxt_s    = hreg_r;
          valid_nxt_s   = 1'b1;
          timeout_nxt_s = 1'b0;
          cnt_nxt_s     = CNT_ONE;
        end else begin
          if (fall_s) begin
            hreg_nxt_s = cnt_r;
          end else begin
            hreg_nxt_s = hreg_r;
          end
          if (cnt_r == CNT_MAX) begin
            timeout_nxt_s = 1'b1;
            state_nxt_s   = IDLE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_WIDTH{1'b0}};
      hreg_r       <= {CNT_WIDTH{1'b0}};
      period       <= {CNT_WIDTH{1'b0}};
      high_time    <= {CNT_WIDTH{1'b0}};
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      hreg_r       <= hreg_nxt_s;
      period       <= period_nxt_s;
      high_time    <= high_nxt_s;
      period_valid <= valid_nxt_s;
      timeout      <= timeout_nxt_s;
    end
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous square-wave input, such as a divided clock or an LED blink signal, in cycles of the system clock `clk_in`. It is the receiving end of a divided-clock link: a divider generates the slow signal and this block recovers its rate, so a design can self-check or report divider output. It synchronizes the input and detects its edges. It reports one measurement per input period with a single-cycle valid strobe, and flags a timeout when the input stops toggling.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: counter and output width, ≥ 2. Maximum measurable period is 2^CNT_WIDTH − 1 cycles.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `sig_in`, ≥ 2.

Ports:
- `clk_in`, input, 1: system clock. It is the single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `sig_in`, input, 1: asynchronous signal under measurement.
- `period`, output, CNT_WIDTH: cycles from one rising edge to the next, measured on the latest completed period.
- `high_time`, output, CNT_WIDTH: cycles from rising edge to falling edge, measured on the same period.
- `period_valid`, output, 1: one-cycle pulse; `period` and `high_time` are updated in this cycle.
- `timeout`, output, 1: level. Set when the counter saturates without a rising edge; cleared on the next `period_valid`.

## Operation
- **Synchronizer and edge detection**
  - `sig_in` passes through a chain of SYNC_STAGES flops, then one history flop `prev`. All of these reset to 0.
  - A rising edge is detected when the synchronized value is 1 and `prev` is 0 (`rise`). A falling edge is detected when the synchronized value is 0 and `prev` is 1 (`fall`).
  - There is no glitch filtering.
- **State machine**, with states IDLE (reset state) and MEASURE:
  - IDLE:
    - `rise` moves to MEASURE and loads `cnt` with 1.
    - No measurement is reported on this arming edge.
  - MEASURE, evaluated in priority order:
    - `rise`: `period` is loaded with `cnt`, `high_time` with `hreg`, `period_valid` pulses, `timeout` is cleared, and `cnt` is loaded with 1. The state stays MEASURE.
    - Otherwise, if `cnt` = 2^CNT_WIDTH − 1: `timeout` is set and the state moves to IDLE. `cnt` holds its value.
    - Otherwise, `cnt` increments by 1.
  - In both MEASURE cases that do not see `rise`, `fall` loads `hreg` with `cnt`.
- **Arithmetic**
  - `cnt` and `hreg` are CNT_WIDTH bits wide and unsigned. `cnt` never wraps.
  - With `rise` detected in cycle k and again in cycle k+P, the reported `period` is P and `high_time` = f − k, where f is the cycle in which `fall` is detected.
- **Reset values**:
  - `period` = 0, `high_time` = 0, `period_valid` = 0, `timeout` = 0.
  - Internal state: `cnt` = 0, `hreg` = 0, state = IDLE.

## Timing
- **Latency:** `period_valid` is high in the cycle after the SYNC_STAGES-th `clk_in` edge following the edge that first samples `sig_in` high. With SYNC_STAGES = 2, that is 2 edges later.
- Outputs are registered. `period` and `high_time` hold their values between pulses.
- **Pulse spacing:** successive `period_valid` pulses are exactly `period` cycles apart for a steady input.
- **Arming:** the first rising edge after reset or after a timeout only arms the block. The first `period_valid` follows the second rising edge.
- **Simultaneous rise and saturation:** if `rise` occurs in the cycle where `cnt` = max, `rise` wins. `period` = 2^CNT_WIDTH − 1 is reported and `timeout` stays 0.
- **Minimum input period:** 2 cycles. Shorter high or low phases may be missed; this is not detected.
- **Reset mid-measurement:**
  - All state is cleared in the cycle after `rst` is sampled high.
  - While `rst` is high, no `period_valid` is produced.
  - After release, the block re-arms on the next rising edge.
- **Timeout persistence:** `timeout` remains 1 through IDLE and re-arming. It clears only together with the next `period_valid`.

## Test plan
- **Steady square wave:** CNT_WIDTH = 16; `sig_in` has a 6-cycle period, 3 cycles high. After the second rising edge, expect `period_valid` every 6 cycles with `period` = 6 and `high_time` = 3.
- **Arming and latency:** release reset, then raise `sig_in`. Expect no pulse on the first edge. On the second edge, expect `period_valid` exactly 2 edges after the edge that samples `sig_in` high (SYNC_STAGES = 2).
- **Timeout and recovery:** CNT_WIDTH = 4; one rising edge, then `sig_in` held high.
  - Expect `timeout` = 1 when `cnt` reaches 15, with no pulse.
  - Then apply a 4-cycle period. Expect the first edge to arm, and the second edge to give `period` = 4 with `timeout` falling to 0 in the same cycle.
- **Boundary:** CNT_WIDTH = 4.
  - Input period 15: expect `period` = 15 and `timeout` = 0.
  - Input period 16: expect `timeout` = 1 and no `period_valid`.
- **Reset mid-measurement:** assert `rst` for 3 cycles in the middle of a period.
  - Expect all outputs at 0 during reset.
  - After release, expect the next rising edge to produce no pulse, and the following rising edge to report the correct period.
- **Duty change:** switch from 3 high / 3 low to 1 high / 5 low. Expect the first full new period to report `period` = 6 and `high_time` = 1.
